// File: rtl/snake_input_queue_if.sv
// snake_input_queue_if: button, step and direction/queue status signals of the snake input queue
interface snake_input_queue_if #(
    parameter int QUEUE_DEPTH = 2
);
    logic                               b_Up;
    logic                               b_Dw;
    logic                               b_Lf;
    logic                               b_Rg;
    logic                               b_Pause;
    logic                               step;
    logic [1:0]                         moveState;
    logic                               isPaused;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count;

    modport master (
        output b_Up, b_Dw, b_Lf, b_Rg, b_Pause, step,
        input  moveState, isPaused, queue_count
    );

    modport slave (
        input  b_Up, b_Dw, b_Lf, b_Rg, b_Pause, step,
        output moveState, isPaused, queue_count
    );
endinterface

// File: rtl/snake_input_queue.sv
// snake_input_queue: debounced buttons, pause toggle and a FIFO of legal turns consumed one per step
module snake_input_queue #(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         QUEUE_DEPTH     = 2,
    parameter logic [1:0] INIT_DIR        = 2'd3
) (
    input  logic              clk,
    input  logic              rst,
    snake_input_queue_if.slave sq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam int NW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] LIM  = CW'(DEBOUNCE_CYCLES - 1);

    logic [4:0]    raw, s1_q, s2_q, db_q, db_d, flip, press;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [1:0]    mem_q [QUEUE_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, newest;
    logic [NW-1:0] count_q, count_d;
    logic [1:0]    move_q, move_d, req, ref_dir;
    logic          paused_q, paused_d, blk, push, pop;

    assign raw = {sq.b_Pause, sq.b_Rg, sq.b_Lf, sq.b_Dw, sq.b_Up};

    // A level flips on the edge the counter would reach DEBOUNCE_CYCLES, so the press is live that cycle
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            flip[i]  = (s2_q[i] != db_q[i]) && (cnt_q[i] == LIM);
            db_d[i]  = db_q[i] ^ flip[i];
            cnt_d[i] = (s2_q[i] == db_q[i] || flip[i]) ? '0 : cnt_q[i] + CW'(1);
        end
        press = flip & s2_q;
    end

    // Turns are legal only across axes: UP/DOWN share bit 1, as do LEFT/RIGHT
    always_comb begin
        blk      = paused_q | press[4];
        req      = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
        newest   = wr_q == '0 ? LAST : wr_q - PW'(1);
        ref_dir  = count_q != '0 ? mem_q[newest] : move_q;
        push     = |press[3:0] & ~blk & (req[1] != ref_dir[1]) & (count_q != NW'(QUEUE_DEPTH));
        pop      = sq.step & ~blk & (count_q != '0);
        wr_d     = push ? (wr_q == LAST ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d     = pop ? (rd_q == LAST ? '0 : rd_q + PW'(1)) : rd_q;
        count_d  = count_q + NW'(push) - NW'(pop);
        move_d   = pop ? mem_q[rd_q] : move_q;
        paused_d = paused_q ^ press[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            move_q   <= INIT_DIR;
            paused_q <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            move_q   <= move_d;
            paused_q <= paused_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= req;
    end

    assign sq.moveState   = move_q;
    assign sq.isPaused    = paused_q;
    assign sq.queue_count = count_q;
endmodule

// File: tb/tb_snake_input_queue.sv
// tb_snake_input_queue: table of button/step actions with a scoreboard, plus hand-written timing corners
module tb_snake_input_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   toggles = 0;
    logic prev_p  = 1'b0;

    snake_input_queue_if #(.QUEUE_DEPTH(2)) sq_if ();

    snake_input_queue #(
        .DEBOUNCE_CYCLES(4),
        .QUEUE_DEPTH(2),
        .INIT_DIR(2'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sq(sq_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_p <= sq_if.isPaused;
        if (!rst && prev_p !== sq_if.isPaused) toggles <= toggles + 1;
    end

    typedef struct {
        logic [4:0] mask;
        int         steps;
        logic [1:0] ms;
        logic [1:0] qc;
        logic       p;
    } vec_t;

    typedef struct {
        logic [1:0] ms;
        logic [1:0] qc;
        logic       p;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(logic [4:0] m);
        {sq_if.b_Pause, sq_if.b_Rg, sq_if.b_Lf, sq_if.b_Dw, sq_if.b_Up} = m;
    endtask

    task automatic press(logic [4:0] m, int hold = 8);
        set_btn(m);
        tick(hold);
        set_btn('0);
        tick(8);
    endtask

    task automatic do_step();
        sq_if.step = 1'b1;
        tick();
        sq_if.step = 1'b0;
        tick();
    endtask

    task automatic check(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   t0;
        set_btn('0);
        sq_if.step = 1'b0;
        vecs = '{
            '{5'b00010, 0, 2'd0, 2'd0, 1'b0},
            '{5'b00001, 0, 2'd0, 2'd0, 1'b0},
            '{5'b00100, 0, 2'd0, 2'd1, 1'b0},
            '{5'b00001, 0, 2'd0, 2'd2, 1'b0},
            '{5'b00010, 0, 2'd0, 2'd2, 1'b0},
            '{5'b00000, 1, 2'd2, 2'd1, 1'b0},
            '{5'b00000, 1, 2'd0, 2'd0, 1'b0},
            '{5'b00000, 1, 2'd0, 2'd0, 1'b0},
            '{5'b01000, 0, 2'd0, 2'd1, 1'b0},
            '{5'b00100, 0, 2'd0, 2'd1, 1'b0},
            '{5'b00000, 1, 2'd3, 2'd0, 1'b0},
            '{5'b00100, 0, 2'd3, 2'd0, 1'b0},
            '{5'b01001, 0, 2'd3, 2'd1, 1'b0},
            '{5'b00000, 1, 2'd0, 2'd0, 1'b0},
            '{5'b01100, 1, 2'd2, 2'd0, 1'b0},
            '{5'b00110, 1, 2'd1, 2'd0, 1'b0}
        };
        tick(3);
        rst = 1'b0;
        tick(20);
        check("reset_moveState", sq_if.moveState, 3);
        check("reset_isPaused", sq_if.isPaused, 0);
        check("reset_count", sq_if.queue_count, 0);

        press(5'b00001, 3);
        check("glitch_no_push", sq_if.queue_count, 0);

        sq_if.b_Up = 1'b1;
        tick(5);
        check("latency_before", sq_if.queue_count, 0);
        tick();
        check("latency_at6", sq_if.queue_count, 1);
        tick(4);
        sq_if.b_Up = 1'b0;
        tick(8);
        do_step();
        check("first_step_ms", sq_if.moveState, 0);
        check("first_step_count", sq_if.queue_count, 0);

        foreach (vecs[i]) begin
            if (vecs[i].mask != '0) press(vecs[i].mask);
            for (int s = 0; s < vecs[i].steps; s++) do_step();
            sb.push_back('{vecs[i].ms, vecs[i].qc, vecs[i].p});
            e = sb.pop_front();
            check($sformatf("vec%0d_ms", i), sq_if.moveState, e.ms);
            check($sformatf("vec%0d_count", i), sq_if.queue_count, e.qc);
            check($sformatf("vec%0d_paused", i), sq_if.isPaused, e.p);
        end

        t0 = toggles;
        press(5'b10000, 20);
        check("pause_hold_paused", sq_if.isPaused, 1);
        check("pause_hold_toggles", toggles - t0, 1);
        press(5'b00100);
        do_step();
        check("paused_ms", sq_if.moveState, 1);
        check("paused_count", sq_if.queue_count, 0);
        press(5'b10000);
        check("unpause", sq_if.isPaused, 0);
        press(5'b10100);
        check("pause_with_dir_paused", sq_if.isPaused, 1);
        check("pause_with_dir_count", sq_if.queue_count, 0);
        press(5'b10000);
        check("unpause2", sq_if.isPaused, 0);

        press(5'b00100);
        check("one_entry", sq_if.queue_count, 1);
        sq_if.b_Up = 1'b1;
        tick(5);
        sq_if.step = 1'b1;
        tick();
        sq_if.step = 1'b0;
        check("pushpop_ms", sq_if.moveState, 2);
        check("pushpop_count", sq_if.queue_count, 1);
        sq_if.b_Up = 1'b0;
        tick(8);
        do_step();
        check("pushpop_next_ms", sq_if.moveState, 0);

        sq_if.b_Lf = 1'b1;
        tick(5);
        sq_if.step = 1'b1;
        tick();
        sq_if.step = 1'b0;
        check("empty_pushpop_ms", sq_if.moveState, 0);
        check("empty_pushpop_count", sq_if.queue_count, 1);
        sq_if.b_Lf = 1'b0;
        tick(8);
        do_step();
        check("empty_pushpop_next_ms", sq_if.moveState, 2);

        press(5'b00001);
        press(5'b01000);
        check("two_queued", sq_if.queue_count, 2);
        press(5'b10000);
        rst = 1'b1;
        tick();
        check("midrst_ms", sq_if.moveState, 3);
        check("midrst_count", sq_if.queue_count, 0);
        check("midrst_paused", sq_if.isPaused, 0);

        sq_if.b_Up = 1'b1;
        tick();
        rst = 1'b0;
        tick(5);
        check("held_rst_before", sq_if.queue_count, 0);
        tick();
        check("held_rst_press", sq_if.queue_count, 1);
        sq_if.b_Up = 1'b0;
        tick(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
